// File: rtl/muxn_rr.sv
// muxn_rr: N-channel registered multiplexer with valid/ready handshaking.
// It selects one input channel per cycle, either by a fixed select or by
// round-robin arbitration, and loads it into a single output register.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. Valid never depends on ready. The output side
// holds out_data/out_ch/out_valid steady while out_valid=1 and out_ready=0.
// Each in_ready[i] is combinational, and at most one bit is high per cycle.
module muxn_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  // Channel arrays are padded to the full select range. Any out-of-range
  // select then reads a defined zero and never indexes past the end.
  localparam int NPAD = 1 << SELW;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  g;
  logic             eligible;
  logic             ld;
  logic             grant;
  logic             sel_in_range;
  logic [NPAD-1:0]  valid_pad;
  logic [WIDTH-1:0] ch_data [NPAD];
  logic [2*NCH-1:0] valid_dbl;
  logic [NCH-1:0]   valid_rot;
  logic             rr_found;
  logic [SELW-1:0]  rr_g;
  logic [SELW:0]    rr_sum;

  for (genvar i = 0; i < NPAD; i++) begin : g_ch
    if (i < NCH) begin : g_real
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[i] = '0;
    end
  end

  // Widen the valid vector to the select range for fixed-select lookup.
  always_comb begin
    valid_pad = '0;
    valid_pad[NCH-1:0] = in_valid;
  end

  // Rotate the valids so that bit k is channel (ptr+k) mod NCH.
  assign valid_dbl = {in_valid, in_valid};
  assign valid_rot = NCH'(valid_dbl >> ptr);

  // Round-robin: take the lowest set rotated bit, then map it back to a channel.
  always_comb begin
    rr_found = 1'b0;
    rr_sum   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        rr_found = 1'b1;
        rr_sum   = {1'b0, ptr} + (SELW+1)'(k);
      end
    end
    if (rr_sum >= (SELW+1)'(NCH)) begin
      rr_sum = rr_sum - (SELW+1)'(NCH);
    end
    rr_g = rr_sum[SELW-1:0];
  end

  assign sel_in_range = ({1'b0, sel} < (SELW+1)'(NCH));

  // Candidate channel and its eligibility for the current mode.
  always_comb begin
    if (mode) begin
      g        = rr_g;
      eligible = rr_found;
    end else begin
      g        = sel;
      eligible = sel_in_range & valid_pad[sel];
    end
  end

  assign ld       = ~out_valid | out_ready;
  assign grant    = ~rst & ld & eligible;
  assign in_ready = grant ? (NCH'(1) << g) : '0;

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[g];
      out_ch    <= g;
      if (mode) begin
        ptr <= (g == SELW'(NCH - 1)) ? '0 : g + 1'b1;
      end
    end else if (ld) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. Selection is either fixed, driven by an external select, or round-robin arbitration across all valid channels. It generalises the 2-to-1 datapath mux into a pipelined steering stage that merges several producers, such as register-file read ports or functional-unit results, onto one consumer bus. It has one register stage and sustains one transfer per cycle.

## Interface
- WIDTH, 32: data width per channel.
- NCH, 4: number of input channels, 2 to 16.
- SELW, 2: select/channel-index width, equal to ceil(log2(NCH)).

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- in_valid  input  NCH  per-channel data-valid.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; combinational.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- Load enable: ld = ~out_valid | out_ready. The output register may be overwritten only when ld = 1.
- Candidate channel g:
  - mode 0: g = sel. The candidate is eligible only if sel < NCH and in_valid[sel] = 1.
  - mode 1: g is the first channel with in_valid set, scanning ptr, ptr+1, ..., ptr+NCH-1, all modulo NCH.
- Grant occurs when ld = 1 and an eligible candidate exists.
- in_ready[i] = ~rst & ld & grant & (i == g). At most one bit of in_ready is set per cycle. A transfer on channel i means in_valid[i] & in_ready[i].
- On grant, at the clock edge:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - If mode = 1, ptr <= (g+1) mod NCH. If mode = 0, ptr holds.
- When ld = 1 and there is no grant: out_valid <= 0. out_data and out_ch hold their previous values.
- When ld = 0 (output stalled): all output state holds, ptr holds, and in_ready = 0.
- ptr is an internal SELW-bit round-robin pointer. It is never exposed and always wraps within 0..NCH-1.
- Mode switches take effect on the cycle the new value is presented. ptr is preserved across mode switches.
- If sel ≥ NCH in mode 0, nothing is granted and in_ready is all zero.

## Timing
- Reset (rst high at an edge): out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. While rst is high, in_ready = 0.
- Reset asserted mid-transfer: the held output word is discarded and no input is accepted in that cycle.
- Latency: data transferred at edge k appears on out_data from edge k through edge k+1.
- Throughput: one word per cycle while out_ready stays high.
- Simultaneous consume and refill: when out_valid = 1, out_ready = 1 and a grant occurs in the same cycle, the new word replaces the old one with no bubble.
- Backpressure: out_data, out_ch and out_valid are stable while out_valid = 1 and out_ready = 0.
- Round-robin fairness: with all channels continuously valid, the grant order is 0, 1, ..., NCH-1, 0, and so on. No channel waits more than NCH-1 grants.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid high. Required: in_ready = 0; out_valid = 0, out_data = 0, out_ch = 0 after the reset edge.
- Fixed select: mode = 0, sel = 2, in_data channel 2 = 32'h5, in_valid = 4'b1111, out_ready = 1. Required: only in_ready[2] = 1; one cycle later out_data = 5 and out_ch = 2. Setting sel = 1 with channel 1 = 32'h3 gives out_data = 3 on the next cycle.
- Round-robin, all valid: mode = 1, channel data 10, 11, 12, 13, out_ready = 1 for 8 cycles. Required: out_ch sequence 0, 1, 2, 3, 0, 1, 2, 3 with matching data and no bubbles.
- Round-robin skip and wrap: mode = 1, ptr = 3 after a grant on channel 2, in_valid = 4'b0010. Required: channel 1 is granted and ptr becomes 2.
- Backpressure: out_valid = 1 with out_data = 32'hA, then out_ready = 0 for 3 cycles with inputs still valid. Required: in_ready = 0 and the outputs stay at A. When out_ready rises, a new word loads in that same cycle.
- Boundaries: mode = 0 with sel = 3 and in_valid[3] = 0 yields no grant. When out_ready is high, out_valid drops to 0 on the next edge. Reset asserted mid-stream clears out_valid on the next edge and no input is accepted in that cycle.
